// File: rtl/round_ctrl.sv
// Duck-hunt round sequencer: spawn, shots, hit/escape, dog/escape hold, round advance and game over.
// Latency: one state step per frame_tick, outputs registered; no backpressure (inputs sampled every tick).
module round_ctrl #(
    parameter int BULLETS         = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int WIN_THRESHOLD   = 6,
    parameter int HOLD_TICKS      = 60
) (
    input  logic       clk,
    input  logic       rst1,
    input  logic       frame_tick,
    input  logic       b_shoot,
    input  logic       hit,
    input  logic       duck_offscreen,
    input  logic       duck_landed,
    output logic [2:0] state,
    output logic       spawn,
    output logic [1:0] bullets_left,
    output logic [3:0] win_count,
    output logic [3:0] round_num,
    output logic       dog_show,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_FLY       = 3'd2,
        S_FALL      = 3'd3,
        S_DOG       = 3'd4,
        S_ESCAPE    = 3'd5,
        S_NEXT      = 3'd6,
        S_GAME_OVER = 3'd7
    } state_t;

    localparam logic [1:0] BUL_INIT  = 2'(BULLETS);
    localparam logic [3:0] DUCKS_L   = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0] THR_L     = 4'(WIN_THRESHOLD);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

    state_t     cur, nxt;
    logic [7:0] tick_cnt, tick_cnt_nxt;
    logic [3:0] duck_idx, duck_idx_nxt;
    logic [3:0] win_nxt, round_nxt;
    logic [1:0] bul_nxt;
    logic       shoot_q;
    logic       shot;

    // Only meaningful on frame_tick cycles: shoot_q is the level seen at the previous tick.
    assign shot  = b_shoot & ~shoot_q;
    assign state = cur;

    always_comb begin
        nxt          = cur;
        bul_nxt      = bullets_left;
        win_nxt      = win_count;
        round_nxt    = round_num;
        duck_idx_nxt = duck_idx;
        tick_cnt_nxt = tick_cnt;
        case (cur)
            S_IDLE: begin
                if (shot) begin
                    nxt          = S_SPAWN;
                    round_nxt    = 4'd1;
                    win_nxt      = 4'd0;
                    duck_idx_nxt = 4'd0;
                end
            end
            S_SPAWN: begin
                bul_nxt = BUL_INIT;
                if (duck_idx < DUCKS_L) duck_idx_nxt = duck_idx + 4'd1;
                nxt = S_FLY;
            end
            S_FLY: begin
                if (shot && bullets_left != 2'd0) begin
                    bul_nxt = bullets_left - 2'd1;
                    if (hit) begin
                        if (win_count != 4'd15) win_nxt = win_count + 4'd1;
                        nxt = S_FALL;
                    end else if (bullets_left == 2'd1 || duck_offscreen) begin
                        nxt          = S_ESCAPE;
                        tick_cnt_nxt = 8'd0;
                    end
                end else if (duck_offscreen) begin
                    nxt          = S_ESCAPE;
                    tick_cnt_nxt = 8'd0;
                end
            end
            S_FALL: begin
                if (duck_landed) begin
                    nxt          = S_DOG;
                    tick_cnt_nxt = 8'd0;
                end
            end
            S_DOG, S_ESCAPE: begin
                if (tick_cnt == HOLD_LAST) nxt = S_NEXT;
                else tick_cnt_nxt = tick_cnt + 8'd1;
            end
            S_NEXT: begin
                if (duck_idx < DUCKS_L) begin
                    nxt = S_SPAWN;
                end else if (win_count >= THR_L) begin
                    if (round_num != 4'd15) round_nxt = round_num + 4'd1;
                    win_nxt      = 4'd0;
                    duck_idx_nxt = 4'd0;
                    nxt          = S_SPAWN;
                end else begin
                    nxt = S_GAME_OVER;
                end
            end
            S_GAME_OVER: begin
                if (shot) begin
                    nxt          = S_IDLE;
                    win_nxt      = 4'd0;
                    round_nxt    = 4'd0;
                    duck_idx_nxt = 4'd0;
                    bul_nxt      = 2'd0;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            cur          <= S_IDLE;
            spawn        <= 1'b0;
            bullets_left <= 2'd0;
            win_count    <= 4'd0;
            round_num    <= 4'd0;
            dog_show     <= 1'b0;
            game_over    <= 1'b0;
            tick_cnt     <= 8'd0;
            duck_idx     <= 4'd0;
            // Held-through-reset button must not look like a fresh press.
            shoot_q      <= 1'b1;
        end else begin
            spawn <= frame_tick && (cur == S_SPAWN);
            if (frame_tick) begin
                shoot_q      <= b_shoot;
                cur          <= nxt;
                bullets_left <= bul_nxt;
                win_count    <= win_nxt;
                round_num    <= round_nxt;
                duck_idx     <= duck_idx_nxt;
                tick_cnt     <= tick_cnt_nxt;
                dog_show     <= (nxt == S_DOG);
                game_over    <= (nxt == S_GAME_OVER);
            end
        end
    end

endmodule
